// File: rtl/time_display_pkg.sv
// Shared definitions for the MM.SS display scanner: digit indices, FSM states,
// the BCD pair type and the 7-segment encoder.
package time_display_pkg;

  localparam logic [1:0] DIG_SEC_U = 2'd0;
  localparam logic [1:0] DIG_SEC_T = 2'd1;
  localparam logic [1:0] DIG_MIN_U = 2'd2;
  localparam logic [1:0] DIG_MIN_T = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV_M = 2'd1,
    ST_CONV_S = 2'd2
  } scan_state_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_pair_t;

  // Active-high gfedcba pattern; codes 10-15 are dark.
  function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
    logic [6:0] pat;
    case (bcd)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bin2bcd6_seq.sv
// Sequential double-dabble: 6-bit binary to two BCD digits in 6 iterations.
// done pulses 7 cycles after an accepted start; results hold until the next done.
module bin2bcd6_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] units
);

  // Shift register layout: {tens[3:0], units[3:0], remaining binary[5:0]}
  logic [13:0] r_shift;
  logic [2:0]  r_iter;
  logic        r_busy;
  logic        r_done;
  logic [3:0]  r_tens;
  logic [3:0]  r_units;
  logic [13:0] w_adj;
  logic [13:0] w_shifted;

  always_comb begin
    w_adj = r_shift;
    if (r_shift[13:10] >= 4'd5) w_adj[13:10] = r_shift[13:10] + 4'd3;
    if (r_shift[9:6] >= 4'd5)   w_adj[9:6]   = r_shift[9:6] + 4'd3;
    w_shifted = {w_adj[12:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_iter  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_tens  <= '0;
      r_units <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        r_shift <= w_shifted;
        r_iter  <= r_iter + 3'd1;
        if (r_iter == 3'd5) begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_tens  <= w_shifted[13:10];
          r_units <= w_shifted[9:6];
        end
      end else if (start) begin
        r_shift <= {8'd0, bin};
        r_iter  <= '0;
        r_busy  <= 1'b1;
      end
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign tens  = r_tens;
  assign units = r_units;

endmodule

// File: rtl/time_display_scanner.sv
// Drives a 4-digit multiplexed 7-segment display as MM.SS from binary counters.
// Values are snapshotted and converted during the last slot and committed at frame start.
module time_display_scanner
  import time_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int               DIV_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [1:0]       r_digit;
  logic             r_init;
  logic             w_tick;
  logic             w_launch;
  logic             w_commit;

  scan_state_t r_state;
  scan_state_t w_state_next;
  logic        r_conv_start;
  logic        w_conv_start_next;
  logic [5:0]  r_snap_m;
  logic [5:0]  r_snap_s;
  logic [5:0]  w_conv_bin;
  logic        w_conv_busy;
  logic        w_conv_done;
  logic [3:0]  w_conv_tens;
  logic [3:0]  w_conv_units;

  bcd_pair_t r_pend_m;
  bcd_pair_t r_pend_s;
  logic      r_pending_ok;
  bcd_pair_t r_disp_m;
  bcd_pair_t r_disp_s;
  logic      r_valid;

  logic [1:0] w_digit_next;
  bcd_pair_t  w_disp_m_next;
  bcd_pair_t  w_disp_s_next;
  logic       w_valid_next;
  logic [3:0] w_bcd;
  logic [3:0] w_an_act;
  logic [6:0] w_seg_act;
  logic       w_dp_act;
  logic [3:0] r_an;
  logic [6:0] r_seg;
  logic       r_dp;

  assign w_tick   = (r_div_cnt == DIV_LAST);
  // r_init is high only on the first cycle after reset release
  assign w_launch = r_init || (w_tick && (r_digit == DIG_MIN_U));
  assign w_commit = w_tick && (r_digit == DIG_MIN_T) && r_pending_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_digit   <= DIG_MIN_T;
      r_init    <= 1'b1;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
      r_digit   <= w_digit_next;
      r_init    <= 1'b0;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_conv_start_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_launch && !w_conv_busy) begin
          w_state_next      = ST_CONV_M;
          w_conv_start_next = 1'b1;
        end
      end
      ST_CONV_M: begin
        if (w_conv_done) begin
          w_state_next      = ST_CONV_S;
          w_conv_start_next = 1'b1;
        end
      end
      ST_CONV_S: begin
        if (w_conv_done) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_conv_start <= 1'b0;
      r_snap_m     <= '0;
      r_snap_s     <= '0;
      r_pend_m     <= '0;
      r_pend_s     <= '0;
      r_pending_ok <= 1'b0;
      r_disp_m     <= '0;
      r_disp_s     <= '0;
      r_valid      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_conv_start <= w_conv_start_next;
      if ((r_state == ST_IDLE) && w_launch) begin
        r_snap_m <= minutes;
        r_snap_s <= seconds;
      end
      if ((r_state == ST_CONV_M) && w_conv_done) r_pend_m <= {w_conv_tens, w_conv_units};
      if ((r_state == ST_CONV_S) && w_conv_done) begin
        r_pend_s     <= {w_conv_tens, w_conv_units};
        r_pending_ok <= 1'b1;
      end else if (w_commit) begin
        r_pending_ok <= 1'b0;
      end
      r_disp_m <= w_disp_m_next;
      r_disp_s <= w_disp_s_next;
      r_valid  <= w_valid_next;
    end
  end

  assign w_conv_bin = (r_state == ST_CONV_S) ? r_snap_s : r_snap_m;

  bin2bcd6_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (r_conv_start),
    .bin   (w_conv_bin),
    .busy  (w_conv_busy),
    .done  (w_conv_done),
    .tens  (w_conv_tens),
    .units (w_conv_units)
  );

  // Outputs are built from next-state values so the new digit appears right after tick
  assign w_digit_next  = w_tick ? r_digit + 2'd1 : r_digit;
  assign w_disp_m_next = w_commit ? r_pend_m : r_disp_m;
  assign w_disp_s_next = w_commit ? r_pend_s : r_disp_s;
  assign w_valid_next  = r_valid | w_commit;

  always_comb begin
    w_bcd = 4'd0;
    case (w_digit_next)
      DIG_SEC_U: w_bcd = w_disp_s_next.units;
      DIG_SEC_T: w_bcd = w_disp_s_next.tens;
      DIG_MIN_U: w_bcd = w_disp_m_next.units;
      DIG_MIN_T: w_bcd = w_disp_m_next.tens;
      default:   w_bcd = 4'd0;
    endcase
    w_an_act  = 4'b0001 << w_digit_next;
    w_seg_act = seg_encode(w_bcd);
    w_dp_act  = (w_digit_next == DIG_MIN_U);
    if (!w_valid_next || blank) begin
      w_an_act  = 4'b0000;
      w_seg_act = 7'h00;
      w_dp_act  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an  <= {4{ACTIVE_LOW}};
      r_seg <= {7{ACTIVE_LOW}};
      r_dp  <= ACTIVE_LOW;
    end else begin
      r_an  <= w_an_act ^ {4{ACTIVE_LOW}};
      r_seg <= w_seg_act ^ {7{ACTIVE_LOW}};
      r_dp  <= w_dp_act ^ ACTIVE_LOW;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_time_display_scanner.sv
// Bench for time_display_scanner: per-cycle expected outputs from a frame-level
// model are queued by the stimulus and popped by an independent monitor.
module tb_time_display_scanner;

  localparam int RD = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       blank = 1'b0;
  logic [5:0] minutes = 6'd0;
  logic [5:0] seconds = 6'd0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  logic       cv_rst = 1'b1;
  logic       cv_start = 1'b0;
  logic [5:0] cv_bin = 6'd0;
  logic       cv_busy;
  logic       cv_done;
  logic [3:0] cv_tens;
  logic [3:0] cv_units;
  bit         cv_finished = 1'b0;

  time_display_scanner #(.REFRESH_DIV(RD), .ACTIVE_LOW(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .minutes (minutes),
    .seconds (seconds),
    .blank   (blank),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  bin2bcd6_seq u_cv (
    .clk   (clk),
    .rst   (cv_rst),
    .start (cv_start),
    .bin   (cv_bin),
    .busy  (cv_busy),
    .done  (cv_done),
    .tens  (cv_tens),
    .units (cv_units)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } out_t;

  out_t       exp_q[$];
  int         n_vec = 0;
  int         n_bad = 0;
  int         run_idx = -1;
  logic [5:0] hist_m [0:8191];
  logic [5:0] hist_s [0:8191];

  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Output expected in the cycle after run cycle r. Slot k begins one cycle
  // after tick k (run cycle 32k+31); frame f shows inputs sampled at its launch.
  function automatic out_t model_out(input int r, input bit in_rst, input bit in_blank);
    out_t o;
    int m, k, f, d, l, mv, sv, val;
    o.an = 4'hF;
    o.seg = 7'h7F;
    o.dp = 1'b1;
    if (in_rst) return o;
    m = r + 1;
    if (m < RD) return o;
    if (in_blank) return o;
    k = (m - RD) / RD;
    f = k / 4;
    d = k % 4;
    l = (f == 0) ? 0 : 4 * RD * f - 1;
    mv = int'(hist_m[l]);
    sv = int'(hist_s[l]);
    case (d)
      0: val = sv % 10;
      1: val = sv / 10;
      2: val = mv % 10;
      default: val = mv / 10;
    endcase
    o.an = ~(4'b0001 << d);
    o.seg = ~seg_ref(val);
    o.dp = (d == 2) ? 1'b0 : 1'b1;
    return o;
  endfunction

  task automatic cycle(input logic r, input logic [5:0] mi, input logic [5:0] se, input logic bl);
    @(negedge clk);
    rst = r;
    minutes = mi;
    seconds = se;
    blank = bl;
    if (r) begin
      run_idx = -1;
    end else begin
      run_idx = run_idx + 1;
      hist_m[run_idx] = mi;
      hist_s[run_idx] = se;
    end
    exp_q.push_back(model_out(run_idx, r, bl));
  endtask

  task automatic run_to(input int target, input logic [5:0] mi, input logic [5:0] se, input logic bl);
    while (run_idx < target) cycle(1'b0, mi, se, bl);
  endtask

  // Monitor: compare DUT outputs with the queued expectation once per cycle.
  initial begin
    out_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if ({an, seg, dp} !== e) begin
          n_bad++;
          $display("FAIL scan_out t=%0t: an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                   $time, an, seg, dp, e.an, e.seg, e.dp);
        end
      end
    end
  end

  // Standalone converter: latency, values, and a start ignored while busy.
  initial begin
    int v, lat;
    repeat (2) @(negedge clk);
    cv_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v = (i == 0) ? 63 : (i == 1) ? 0 : (i == 2) ? 59 : int'($urandom_range(63));
      @(negedge clk);
      cv_bin = v[5:0];
      cv_start = 1'b1;
      lat = 0;
      do begin
        @(posedge clk);
        #1;
        lat++;
        if (lat == 3) begin
          cv_start = 1'b1;
          cv_bin = ~v[5:0];
        end else begin
          cv_start = 1'b0;
        end
      end while (!cv_done && lat < 20);
      n_vec++;
      if (lat != 7 || !cv_done) begin
        n_bad++;
        $display("FAIL conv_latency bin=%0d: done after %0d cycles, expected 7", v, lat);
      end
      n_vec++;
      if (cv_tens !== 4'(v / 10)) begin
        n_bad++;
        $display("FAIL conv_tens bin=%0d: got %0d, expected %0d", v, cv_tens, v / 10);
      end
      n_vec++;
      if (cv_units !== 4'(v % 10)) begin
        n_bad++;
        $display("FAIL conv_units bin=%0d: got %0d, expected %0d", v, cv_units, v % 10);
      end
    end
    cv_finished = 1'b1;
  end

  initial begin
    logic [5:0] rm, rs;
    logic       rb;
    repeat (3) cycle(1'b1, 6'd12, 6'd34, 1'b0);
    run_to(40, 6'd12, 6'd34, 1'b0);
    run_to(300, 6'd12, 6'd35, 1'b0);
    run_to(388, 6'd12, 6'd59, 1'b0);
    run_to(700, 6'd13, 6'd0, 1'b0);
    run_to(1040, 6'd63, 6'd0, 1'b0);
    run_to(1080, 6'd7, 6'd45, 1'b1);
    run_to(1416, 6'd7, 6'd45, 1'b0);
    cycle(1'b1, 6'd7, 6'd45, 1'b0);
    run_to(300, 6'd41, 6'd8, 1'b0);
    rm = 6'd20;
    rs = 6'd30;
    rb = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) begin
        rm = 6'($urandom_range(63));
        rs = 6'($urandom_range(63));
      end
      if ($urandom_range(63) == 0) rb = ~rb;
      cycle(($urandom_range(999) == 0) ? 1'b1 : 1'b0, rm, rs, rb);
    end
    repeat (3) cycle(1'b0, rm, rs, 1'b0);
    @(posedge clk);
    #2;
    n_vec++;
    if (!cv_finished) begin
      n_bad++;
      $display("FAIL conv_timeout: converter check finished=%b, expected 1", cv_finished);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
